// File: rtl/gate_sequencer_if.sv
// gate_sequencer_if: bundles the host control/status signals and the multiplier link of the
// gate sequencer.
//   slave  : sequencer side (i_* inputs, o_* outputs)
//   master : host/multiplier side (drives i_*, observes o_*)
// Signals:
//   i_start, i_num_gates, i_init_state           sequence control
//   i_gate_wr_en, i_gate_wr_addr, i_gate_wr_data gate memory write port
//   o_mult_state, o_mult_gate, i_mult_out_state  multiplier operands and result
//   o_gate_idx, o_busy, o_done, o_final_state    status and result
// Each 32-bit element is {real[31:16], imag[15:0]}, sign-magnitude Q1.14.
interface gate_sequencer_if #(
  parameter int unsigned N         = 2,
  parameter int unsigned MAX_GATES = 8
);
  localparam int unsigned V   = 1 << N;
  localparam int unsigned SW  = 32 * V;
  localparam int unsigned GW  = 32 * V * V;
  localparam int unsigned AW  = $clog2(MAX_GATES);
  localparam int unsigned NGW = $clog2(MAX_GATES) + 1;

  logic           i_start;
  logic [NGW-1:0] i_num_gates;
  logic [SW-1:0]  i_init_state;
  logic           i_gate_wr_en;
  logic [AW-1:0]  i_gate_wr_addr;
  logic [GW-1:0]  i_gate_wr_data;
  logic [SW-1:0]  o_mult_state;
  logic [GW-1:0]  o_mult_gate;
  logic [SW-1:0]  i_mult_out_state;
  logic [AW-1:0]  o_gate_idx;
  logic           o_busy;
  logic           o_done;
  logic [SW-1:0]  o_final_state;

  modport slave (
    input  i_start, i_num_gates, i_init_state,
    input  i_gate_wr_en, i_gate_wr_addr, i_gate_wr_data,
    input  i_mult_out_state,
    output o_mult_state, o_mult_gate, o_gate_idx, o_busy, o_done, o_final_state
  );

  modport master (
    output i_start, i_num_gates, i_init_state,
    output i_gate_wr_en, i_gate_wr_addr, i_gate_wr_data,
    output i_mult_out_state,
    input  o_mult_state, o_mult_gate, o_gate_idx, o_busy, o_done, o_final_state
  );
endinterface

// File: rtl/gate_sequencer.sv
// gate_sequencer: control stage for a combinational gate x state complex multiplier.
// Holds the 2^N-element state vector and a MAX_GATES-deep gate matrix memory. On start it
// applies gates 0..num_gates-1 in order: each gate and the current state are held on the
// multiplier inputs for SETTLE cycles, then the multiplier result is latched as the new state.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset (gate memory is not reset)
//   io_bus : gate_sequencer_if.slave (control, gate write port, multiplier link, status)
// The block performs no arithmetic; it only routes and stores data.
module gate_sequencer #(
  parameter int unsigned N         = 2,
  parameter int unsigned MAX_GATES = 8,
  parameter int unsigned SETTLE    = 4
) (
  input  logic            clk,
  input  logic            rst,
  gate_sequencer_if.slave io_bus
);
  localparam int unsigned V   = 1 << N;
  localparam int unsigned SW  = 32 * V;
  localparam int unsigned GW  = 32 * V * V;
  localparam int unsigned AW  = $clog2(MAX_GATES);
  localparam int unsigned NGW = $clog2(MAX_GATES) + 1;
  // Counter must hold SETTLE itself (value reached on the APPLY->CAPTURE edge).
  localparam int unsigned CW  = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {StIdle, StLoad, StApply, StCapture, StDone} state_e;

  state_e         r_state, w_state_next;
  logic [SW-1:0]  r_state_vec, w_state_vec_next;
  logic [AW-1:0]  r_gate_idx, w_gate_idx_next;
  logic [CW-1:0]  r_cnt, w_cnt_next;
  logic [NGW-1:0] r_num_gates, w_num_gates_next;
  logic [GW-1:0]  r_gate_mem [MAX_GATES];

  logic [NGW-1:0] w_ng_clamped;
  logic           w_last_gate;
  logic           w_settled;
  logic           w_mem_we;

  assign w_ng_clamped = (io_bus.i_num_gates > NGW'(MAX_GATES)) ? NGW'(MAX_GATES)
                                                                : io_bus.i_num_gates;
  assign w_last_gate  = ({1'b0, r_gate_idx} == (r_num_gates - NGW'(1)));
  assign w_settled    = (r_cnt == CW'(SETTLE - 1));
  // Writes only land while idle so the gate on the multiplier never changes mid-sequence.
  assign w_mem_we     = io_bus.i_gate_wr_en && (r_state == StIdle);

  always_comb begin
    w_state_next     = r_state;
    w_state_vec_next = r_state_vec;
    w_gate_idx_next  = r_gate_idx;
    w_cnt_next       = r_cnt;
    w_num_gates_next = r_num_gates;
    unique case (r_state)
      StIdle: begin
        if (io_bus.i_start) begin
          w_num_gates_next = w_ng_clamped;
          w_state_next     = StLoad;
        end
      end
      StLoad: begin
        w_state_vec_next = io_bus.i_init_state;
        w_gate_idx_next  = '0;
        w_cnt_next       = '0;
        w_state_next     = (r_num_gates == '0) ? StDone : StApply;
      end
      StApply: begin
        w_cnt_next = r_cnt + CW'(1);
        if (w_settled) w_state_next = StCapture;
      end
      StCapture: begin
        w_state_vec_next = io_bus.i_mult_out_state;
        w_cnt_next       = '0;
        if (w_last_gate) begin
          w_state_next = StDone;
        end else begin
          w_gate_idx_next = r_gate_idx + AW'(1);
          w_state_next    = StApply;
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_state_vec <= '0;
      r_gate_idx  <= '0;
      r_cnt       <= '0;
      r_num_gates <= '0;
    end else begin
      r_state     <= w_state_next;
      r_state_vec <= w_state_vec_next;
      r_gate_idx  <= w_gate_idx_next;
      r_cnt       <= w_cnt_next;
      r_num_gates <= w_num_gates_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_gate_mem[io_bus.i_gate_wr_addr] <= io_bus.i_gate_wr_data;
  end

  assign io_bus.o_mult_state  = r_state_vec;
  assign io_bus.o_final_state = r_state_vec;
  assign io_bus.o_mult_gate   = r_gate_mem[r_gate_idx];
  assign io_bus.o_gate_idx    = r_gate_idx;
  assign io_bus.o_busy        = (r_state == StLoad) || (r_state == StApply) ||
                                (r_state == StCapture);
  assign io_bus.o_done        = (r_state == StDone);
endmodule
